// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
// It holds the FSM state encodings, the default PC width and the target alignment check.
package branch_redirect_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_REDIRECT = 2'd1,
    RD_FLUSH    = 2'd2
  } rd_state_t;

  // Targets must be word aligned; a nonzero low pair of bits is a misaligned fetch.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Counter that saturates at all-ones and never wraps.
// A synchronous clear takes priority over an increment in the same cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a resolved taken branch or jump from EX into a registered PC redirect toward IF.
// It also raises a multi-cycle wrong-path flush and keeps the branch and taken counters.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             ex_jump,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             if_stall,
  input  logic             cnt_clr,
  output logic             pc_load,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic             misalign_pulse,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [1:0]       dbg_state
);

  localparam int FW = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;

  rd_state_t      state;
  logic [FW-1:0]  fcnt;
  logic           evt;
  logic           in_idle;

  assign evt       = ex_valid & ((ex_branch & ex_taken) | ex_jump);
  assign in_idle   = (state == RD_IDLE);
  assign busy      = ~in_idle;
  assign dbg_state = state;

  // IF handshake: pc_load is a valid that holds with a stable redirect_pc
  // until a cycle where if_stall is low, which is the cycle the load is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RD_IDLE;
      pc_load        <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      misalign_pulse <= 1'b0;
      fcnt           <= '0;
    end else begin
      misalign_pulse <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (evt) begin
            if (is_misaligned(ex_target[1:0])) begin
              misalign_pulse <= 1'b1;
            end else begin
              redirect_pc <= ex_target;
              pc_load     <= 1'b1;
              flush       <= 1'b1;
              state       <= RD_REDIRECT;
            end
          end
        end
        RD_REDIRECT: begin
          if (!if_stall) begin
            pc_load <= 1'b0;
            if (FLUSH_DEPTH == 1) begin
              flush <= 1'b0;
              state <= RD_IDLE;
            end else begin
              fcnt  <= FW'(FLUSH_DEPTH - 2);
              state <= RD_FLUSH;
            end
          end
        end
        RD_FLUSH: begin
          if (fcnt == '0) begin
            flush <= 1'b0;
            state <= RD_IDLE;
          end else begin
            fcnt <= fcnt - FW'(1);
          end
        end
        default: begin
          pc_load <= 1'b0;
          flush   <= 1'b0;
          state   <= RD_IDLE;
        end
      endcase
    end
  end

  // Wrong-path instructions arrive while busy, so only IDLE cycles are counted.
  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (in_idle & ex_valid & ex_branch),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (in_idle & ex_valid & ex_branch & ex_taken),
    .count (taken_count)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with 4-bit counters and FLUSH_DEPTH=2.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_taken;
  logic        ex_jump;
  logic [31:0] ex_target;
  logic        if_stall;
  logic        cnt_clr;
  logic        pc_load;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic        misalign_pulse;
  logic [3:0]  br_count;
  logic [3:0]  taken_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_DEPTH(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_taken       (ex_taken),
    .ex_jump        (ex_jump),
    .ex_target      (ex_target),
    .if_stall       (if_stall),
    .cnt_clr        (cnt_clr),
    .pc_load        (pc_load),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy),
    .misalign_pulse (misalign_pulse),
    .br_count       (br_count),
    .taken_count    (taken_count),
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    ex_jump   = 1'b0;
    ex_target = 32'h0;
    if_stall  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic drive_branch(input logic taken, input logic [31:0] tgt);
    ex_valid  = 1'b1;
    ex_branch = 1'b1;
    ex_taken  = taken;
    ex_jump   = 1'b0;
    ex_target = tgt;
  endtask

  task automatic drive_jump(input logic [31:0] tgt);
    ex_valid  = 1'b1;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    ex_jump   = 1'b1;
    ex_target = tgt;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_pc_load", pc_load, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_misalign", misalign_pulse, 0);
    chk("rst_br", br_count, 0);
    chk("rst_taken", taken_count, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // Taken branch to 0x40
    drive_branch(1'b1, 32'h40);
    tick();
    set_idle();
    chk("beq_pc_load", pc_load, 1);
    chk("beq_redirect_pc", redirect_pc, 32'h40);
    chk("beq_flush_n1", flush, 1);
    chk("beq_br", br_count, 1);
    chk("beq_taken", taken_count, 1);
    chk("beq_state_redirect", dbg_state, 1);
    tick();
    chk("beq_pc_load_n2", pc_load, 0);
    chk("beq_flush_n2", flush, 1);
    chk("beq_state_flush", dbg_state, 2);
    tick();
    chk("beq_flush_n3", flush, 0);
    chk("beq_busy_n3", busy, 0);

    // Not-taken branch, then JAL to 0x100
    drive_branch(1'b0, 32'h80);
    tick();
    set_idle();
    chk("nt_pc_load", pc_load, 0);
    chk("nt_busy", busy, 0);
    chk("nt_br", br_count, 2);
    chk("nt_taken", taken_count, 1);
    drive_jump(32'h100);
    tick();
    set_idle();
    chk("jal_pc_load", pc_load, 1);
    chk("jal_redirect_pc", redirect_pc, 32'h100);
    chk("jal_br", br_count, 2);
    chk("jal_taken", taken_count, 1);
    tick();
    tick();
    chk("jal_done", busy, 0);

    // Stall hold: IF stalls for three cycles after the event
    drive_jump(32'h180);
    tick();
    set_idle();
    if_stall = 1'b1;
    chk("stall_n1_pc_load", pc_load, 1);
    chk("stall_n1_redirect_pc", redirect_pc, 32'h180);
    tick();
    chk("stall_n2_pc_load", pc_load, 1);
    chk("stall_n2_flush", flush, 1);
    tick();
    chk("stall_n3_pc_load", pc_load, 1);
    chk("stall_n3_redirect_pc", redirect_pc, 32'h180);
    tick();
    if_stall = 1'b0;
    chk("stall_n4_pc_load", pc_load, 1);
    chk("stall_n4_flush", flush, 1);
    tick();
    chk("stall_n5_pc_load", pc_load, 0);
    chk("stall_n5_flush", flush, 1);
    tick();
    chk("stall_n6_flush", flush, 0);
    chk("stall_n6_busy", busy, 0);

    // Wrong-path events during REDIRECT and FLUSH are ignored
    drive_branch(1'b1, 32'h1C0);
    tick();
    chk("wp_redirect_pc", redirect_pc, 32'h1C0);
    chk("wp_br_first", br_count, 3);
    drive_branch(1'b1, 32'h200);
    tick();
    chk("wp_flush_pc", redirect_pc, 32'h1C0);
    chk("wp_flush_br", br_count, 3);
    tick();
    set_idle();
    chk("wp_idle_flush", flush, 0);
    chk("wp_idle_pc", redirect_pc, 32'h1C0);
    chk("wp_idle_br", br_count, 3);
    chk("wp_idle_taken", taken_count, 2);
    chk("wp_idle_misalign", misalign_pulse, 0);

    // Back-to-back: event in the first IDLE cycle after FLUSH
    drive_jump(32'h240);
    tick();
    set_idle();
    chk("b2b_pc_load", pc_load, 1);
    chk("b2b_redirect_pc", redirect_pc, 32'h240);
    tick();
    tick();
    chk("b2b_done", busy, 0);

    // Misaligned jump target
    drive_jump(32'h42);
    tick();
    set_idle();
    chk("mis_pulse", misalign_pulse, 1);
    chk("mis_pc_load", pc_load, 0);
    chk("mis_busy", busy, 0);
    chk("mis_redirect_pc", redirect_pc, 32'h240);
    tick();
    chk("mis_pulse_gone", misalign_pulse, 0);

    // Saturation: misaligned taken branches stay in IDLE and count every cycle
    for (int i = 0; i < 17; i++) begin
      drive_branch(1'b1, 32'h2);
      tick();
      if (i == 11) begin
        chk("sat_mid_br", br_count, 4'hF);
        chk("sat_mid_taken", taken_count, 4'hE);
      end
    end
    set_idle();
    chk("sat_br", br_count, 4'hF);
    chk("sat_taken", taken_count, 4'hF);
    chk("sat_busy", busy, 0);

    // Clear wins over a simultaneous branch
    drive_branch(1'b1, 32'h6);
    cnt_clr = 1'b1;
    tick();
    set_idle();
    chk("clr_br", br_count, 0);
    chk("clr_taken", taken_count, 0);
    drive_branch(1'b0, 32'h0);
    tick();
    set_idle();
    chk("post_clr_br", br_count, 1);
    chk("post_clr_taken", taken_count, 0);

    // Reset during FLUSH aborts everything
    drive_jump(32'h300);
    tick();
    set_idle();
    tick();
    chk("rf_flush_pre", flush, 1);
    chk("rf_state_pre", dbg_state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_flush", flush, 0);
    chk("rf_busy", busy, 0);
    chk("rf_pc_load", pc_load, 0);
    chk("rf_redirect_pc", redirect_pc, 0);
    chk("rf_br", br_count, 0);
    chk("rf_taken", taken_count, 0);
    tick();
    chk("rf_stays_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Consumer end of the branch decision path in the pipelined core.
- Takes the resolved taken/not-taken result and target from EX, and registers a PC redirect toward IF.
- Generates a multi-cycle flush of wrong-path instructions.
- Keeps saturating branch/taken performance counters and flags misaligned targets.

Parameters:
- XLEN, 32, width of PC/target.
- FLUSH_DEPTH, 2, total cycles flush is asserted per redirect (>=1).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX holds a real (non-bubble) instruction this cycle.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_taken  in  1  branch condition result for EX instruction (0 when not a branch).
- ex_jump  in  1  EX instruction is JAL/JALR (unconditional).
- ex_target  in  XLEN  computed branch/jump target.
- if_stall  in  1  IF cannot accept a PC load this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_load  out  1  IF must load redirect_pc this cycle.
- redirect_pc  out  XLEN  registered redirect target.
- flush  out  1  squash IF/ID and ID/EX contents this cycle.
- busy  out  1  state != IDLE.
- misalign_pulse  out  1  one-cycle pulse: taken/jump target with target[1:0]!=0.
- br_count  out  CNT_W  conditional branches resolved.
- taken_count  out  CNT_W  conditional branches taken.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; pc_load=0, redirect_pc=0, flush=0, misalign_pulse=0, br_count=0, taken_count=0. Reset mid-REDIRECT/FLUSH aborts immediately; no pending redirect survives.
- Event definition: evt = ex_valid & ((ex_branch & ex_taken) | ex_jump). Events are sampled only in IDLE.
- States:
  - IDLE: pc_load=0, flush=0.
    - evt with ex_target[1:0]==0: latch ex_target into redirect_pc; next state REDIRECT.
    - evt with misaligned target: no redirect; misalign_pulse=1 next cycle only; stay IDLE.
  - REDIRECT: pc_load=1, flush=1.
    - if_stall=1: hold REDIRECT; outputs and redirect_pc unchanged.
    - if_stall=0: load is accepted this cycle. If FLUSH_DEPTH==1, next state IDLE. Otherwise load flush counter with FLUSH_DEPTH-2 and go to FLUSH.
  - FLUSH: pc_load=0, flush=1.
    - Counter==0: next state IDLE. Otherwise decrement.
    - if_stall does not extend FLUSH.
- Latency: evt at cycle N gives pc_load=1 at N+1 (if unstalled). Flush is high for exactly FLUSH_DEPTH consecutive cycles starting N+1, plus any stall-hold cycles.
- Inputs during REDIRECT/FLUSH are wrong-path: ignored for redirect, misalign, and counters.
- Back-to-back: an evt in the first IDLE cycle after FLUSH is accepted normally.
- Counters (only in IDLE, only when ex_valid & ex_branch):
  - br_count += 1; taken_count += 1 if ex_taken.
  - Both saturate at all-ones; no wrap.
  - ex_jump never counts.
  - cnt_clr=1 forces both to 0 that cycle and wins over a simultaneous increment.
- redirect_pc holds its last value outside REDIRECT.

Decomposition:
- Shared defines file: state encodings (RD_IDLE=2'd0, RD_REDIRECT=2'd1, RD_FLUSH=2'd2), XLEN default.
- One sub-module: sat_counter (params W; ports clk, rst, clr, inc, count). Instantiated twice.

Test Plan:
- Taken BEQ: ex_valid=1, ex_branch=1, ex_taken=1, ex_target=0x0000_0040 at cycle N -> pc_load=1 and redirect_pc=0x40 at N+1, flush=1 at N+1..N+2, busy=0 at N+3; br_count=1, taken_count=1.
- Not-taken branch then JAL: branch with ex_taken=0 -> no pc_load, br_count=1, taken_count=0. Then ex_jump=1, target 0x100 -> redirect to 0x100; counters unchanged.
- Stall hold: evt at N with if_stall=1 for N+1..N+3 -> pc_load and flush stay 1 with redirect_pc constant through N+3. Load accepted at N+4; flush low from N+6.
- Wrong-path ignore: second evt (target 0x200) presented during REDIRECT and FLUSH -> redirect_pc stays at first target; counters unchanged.
- Misaligned: ex_jump=1, ex_target=0x0000_0042 -> misalign_pulse=1 for one cycle, pc_load=0, state IDLE.
- Saturation/clear/reset, with CNT_W=4:
  - 17 taken branches -> both counters =4'hF.
  - cnt_clr with a simultaneous branch -> both 0.
  - rst asserted during FLUSH -> next cycle flush=0, busy=0, all counters 0.
